// File: rtl/seg7_pkg.sv
// Shared types, sizes and the hex-to-segment table for the serial 7-segment display path.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

  localparam int FRAME_BITS = 64;
  localparam int DIGITS     = 8;

  // Segment pattern with lit = 1, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_serial_shifter_if.sv
// Request/status and serial-bus bundle between a frame producer and the display shifter.
interface seg7_serial_shifter_if;
  logic [31:0] data;
  logic [7:0]  point;
  logic [7:0]  les;
  logic        start;
  logic        busy;
  logic        done;
  logic [3:0]  sout;

  modport master (
    output data, point, les, start,
    input  busy, done, sout
  );

  modport slave (
    input  data, point, les, start,
    output busy, done, sout
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// One digit: nibble + decimal point + blank request -> on-wire segment byte {dp,g,f,e,d,c,b,a}.
module seg7_hex_decode
  import seg7_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] lit;

  // Blanking forces every segment unlit; wire polarity is applied last.
  always_comb begin
    lit = blank ? 8'h00 : {dp, hex7(nib)};
    seg = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

endmodule

// File: rtl/seg7_serial_shifter.sv
// Builds an 8-digit segment frame and shifts it MSB-first into a 74HC595-style chain, then latches it.
module seg7_serial_shifter
  import seg7_pkg::*;
#(
  parameter int SCLK_HALF  = 4,
  parameter int BLINK_BITS = 25,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_serial_shifter_if.slave  bus
);

  localparam int CW = (2 * SCLK_HALF > 1) ? $clog2(2 * SCLK_HALF) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_LATCH = LATCH;

  localparam logic [CW-1:0] CYC_BIT_END  = CW'(2 * SCLK_HALF - 1);
  localparam logic [CW-1:0] CYC_HALF     = CW'(SCLK_HALF);
  localparam logic [CW-1:0] CYC_HALF_END = CW'(SCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_LAST     = BW'(FRAME_BITS - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic                  clr_q, clr_d;
  logic                  done_q, done_d;

  logic                  phase;
  logic [FRAME_BITS-1:0] frame_build;
  logic                  sclk, sdo, pen;

  assign phase = blink_q[BLINK_BITS-1];

  // Digit 7 lands in the top byte so it leaves the shift register first.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_hex_decode #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_dec (
      .nib   (bus.data[4*g +: 4]),
      .dp    (bus.point[g]),
      .blank (bus.les[g] & phase),
      .seg   (frame_build[8*g +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    frame_d = frame_q;
    blink_d = blink_q + BLINK_BITS'(1);
    clr_d   = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        frame_d = frame_build;
        cyc_d   = '0;
        bit_d   = '0;
        state_d = ST_SHIFT;
      end

      // Each bit: SCLK_HALF cycles low then SCLK_HALF high; shift only after the high half.
      ST_SHIFT: begin
        if (cyc_q == CYC_BIT_END) begin
          cyc_d   = '0;
          frame_d = {frame_q[FRAME_BITS-2:0], 1'b0};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) begin
            state_d = ST_LATCH;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      ST_LATCH: begin
        if (cyc_q == CYC_HALF_END) begin
          cyc_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      blink_q <= '0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      blink_q <= blink_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  // pen is gated by clr_q so a reset never produces a latch pulse on a partial frame.
  always_comb begin
    sclk = (state_q == ST_SHIFT) && (cyc_q >= CYC_HALF);
    sdo  = (state_q == ST_SHIFT) && frame_q[FRAME_BITS-1];
    pen  = clr_q && ((state_q == ST_IDLE) || (state_q == ST_LATCH));
  end

  assign bus.sout = {sclk, sdo, pen, clr_q};
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_seg7_serial_shifter.sv
// Directed bench for seg7_serial_shifter: reset, frame contents, blink, handshake and mid-frame reset.
module tb_seg7_serial_shifter;

  localparam int SH = 4;
  localparam int BB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_serial_shifter_if bus();

  seg7_serial_shifter #(
    .SCLK_HALF  (SH),
    .BLINK_BITS (BB),
    .ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference copy of the free-running blink counter.
  logic [BB-1:0] m;
  always @(posedge clk) begin
    if (rst) m <= '0;
    else     m <= m + BB'(1);
  end

  int checks   = 0;
  int failures = 0;

  logic [63:0] cap;
  int nbits, busy_n, done_n, done_at, pen_rise_bit, pen_hi;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    cap = '0; nbits = 0; busy_n = 0; done_n = 0; done_at = -1; pen_rise_bit = -1;
  endtask

  // Samples ncyc negedges; drops start before sample drop_at, pulses start before sample pulse_at.
  task automatic watch(input int ncyc, input int drop_at, input int pulse_at);
    logic prev_sclk, prev_pen;
    prev_sclk = 1'b0;
    prev_pen  = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      if (i == drop_at) bus.start = 1'b0;
      if (pulse_at >= 0 && i == pulse_at) bus.start = 1'b1;
      if (pulse_at >= 0 && i == pulse_at + 1) bus.start = 1'b0;
      @(negedge clk);
      if (bus.sout[3] && !prev_sclk) begin
        cap = {cap[62:0], bus.sout[2]};
        nbits++;
      end
      if (bus.sout[1] && !prev_pen && pen_rise_bit < 0) pen_rise_bit = nbits;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      prev_sclk = bus.sout[3];
      prev_pen  = bus.sout[1];
    end
  endtask

  task automatic wait_phase(input logic ph);
    logic [BB-1:0] nx;
    for (int k = 0; k < 40; k++) begin
      nx = m + BB'(1);
      if (nx[BB-1] == ph) break;
      @(negedge clk);
    end
  endtask

  initial begin
    bus.data  = '0;
    bus.point = '0;
    bus.les   = '0;
    bus.start = 1'b0;
    rst       = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_sout", 64'(bus.sout), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_sout", 64'(bus.sout), 64'h3);

    // Basic frame
    bus.data = 32'h01234567; bus.point = 8'h01; bus.les = 8'h00;
    clear_obs();
    bus.start = 1'b1;
    watch(600, 1, -1);
    chk("basic_bits",  cap, 64'hC0F9A4B099928278);
    chk("basic_nbits", 64'(nbits), 64'd64);
    chk("basic_busy",  64'(busy_n), 64'd517);
    chk("basic_done",  64'(done_n), 64'd1);
    chk("basic_done_at", 64'(done_at), 64'd517);
    chk("basic_pen_rise", 64'(pen_rise_bit), 64'd64);

    // Letters
    bus.data = 32'hFEDCBA98; bus.point = 8'h00; bus.les = 8'h00;
    clear_obs();
    bus.start = 1'b1;
    watch(600, 1, -1);
    chk("letters_bits", cap, 64'h8E86A1C683889080);
    chk("letters_done", 64'(done_n), 64'd1);

    // Blink, phase 1 at LOAD
    bus.data = 32'h01234567; bus.point = 8'h01; bus.les = 8'hF0;
    wait_phase(1'b1);
    clear_obs();
    bus.start = 1'b1;
    watch(600, 1, -1);
    chk("blink1_bits", cap, 64'hFFFFFFFF99928278);

    // Blink, phase 0 at LOAD
    wait_phase(1'b0);
    clear_obs();
    bus.start = 1'b1;
    watch(600, 1, -1);
    chk("blink0_bits", cap, 64'hC0F9A4B099928278);

    // Start pulse in mid-SHIFT is ignored
    bus.les = 8'h00;
    clear_obs();
    bus.start = 1'b1;
    watch(700, 1, 260);
    chk("ignore_done",  64'(done_n), 64'd1);
    chk("ignore_nbits", 64'(nbits), 64'd64);
    chk("ignore_bits",  cap, 64'hC0F9A4B099928278);
    chk("ignore_busy_end", 64'(bus.busy), 64'h0);

    // Start held high: back-to-back frames
    clear_obs();
    bus.start = 1'b1;
    watch(518, -1, -1);
    chk("held_done1",    64'(done_n), 64'd1);
    chk("held_done1_at", 64'(done_at), 64'd517);
    @(negedge clk);
    chk("held_reload_busy", 64'(bus.busy), 64'h1);
    chk("held_reload_pen",  64'(bus.sout[1]), 64'h0);
    bus.start = 1'b0;
    clear_obs();
    watch(517, -1, -1);
    chk("held_done2",    64'(done_n), 64'd1);
    chk("held_done2_at", 64'(done_at), 64'd516);
    chk("held_bits2",    cap, 64'hC0F9A4B099928278);

    // Reset in the middle of SHIFT
    clear_obs();
    bus.start = 1'b1;
    begin
      logic prev_sclk;
      prev_sclk = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (i == 1) bus.start = 1'b0;
        @(negedge clk);
        if (bus.sout[3] && !prev_sclk) nbits++;
        prev_sclk = bus.sout[3];
        if (nbits == 20) break;
      end
    end
    chk("midrst_reached", 64'(nbits), 64'd20);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_sout", 64'(bus.sout), 64'h0);
    chk("midrst_busy", 64'(bus.busy), 64'h0);
    pen_hi = 0; done_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.sout[1]) pen_hi++;
      if (bus.done) done_n++;
    end
    chk("midrst_pen",  64'(pen_hi), 64'd0);
    chk("midrst_done", 64'(done_n), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_sout", 64'(bus.sout), 64'h3);
    chk("midrst_idle_done", 64'(bus.done), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
